// File: rtl/lutram_pkg.sv
// Shared sizing helpers and default constants for the LUTRAM FIFO.
package lutram_pkg;

   function automatic int depth_f(input int aw);
      return 1 << aw;
   endfunction

   function automatic int cnt_w_f(input int aw);
      return aw + 1;
   endfunction

   function automatic int afull_def_f(input int aw);
      return (1 << aw) - 2;
   endfunction

   localparam int DEF_ADDR_WIDTH   = 7;
   localparam int DEF_AFULL_THRESH = afull_def_f(DEF_ADDR_WIDTH);

endpackage

// File: rtl/lutram_sdp.sv
// Simple dual-port distributed RAM: clocked write, combinational read.
module lutram_sdp
   import lutram_pkg::*;
#(
   parameter int       DATA_WIDTH       = 8,
   parameter int       ADDR_WIDTH       = 7,
   parameter bit       IS_WCLK_INVERTED = 1'b0
) (
   input  logic                  i_wclk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_wa,
   input  logic [DATA_WIDTH-1:0] i_wd,
   input  logic [ADDR_WIDTH-1:0] i_ra,
   output logic [DATA_WIDTH-1:0] o_rd
);

   localparam int DEPTH = depth_f(ADDR_WIDTH);

   logic                  w_clk;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

   assign w_clk = i_wclk ^ IS_WCLK_INVERTED;

   always_ff @(posedge w_clk) begin
      if (i_we) r_mem[i_wa] <= i_wd;
   end

   assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO on distributed RAM with registered flags.
module lutram_fifo
   import lutram_pkg::*;
#(
   parameter int DATA_WIDTH       = 8,
   parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
   parameter int AFULL_THRESH     = afull_def_f(ADDR_WIDTH),
   parameter bit IS_WCLK_INVERTED = 1'b0
) (
   input  logic                  WCLK,
   input  logic                  RST_N,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  RD_EN,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic                  ALMOST_FULL,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int CW = cnt_w_f(ADDR_WIDTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(depth_f(ADDR_WIDTH));
   localparam logic [CW-1:0] THR_C   = CW'(AFULL_THRESH);

   logic                  w_clk;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [CW-1:0]         w_cnt_n;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_cnt;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_afull;
   logic                  r_ovf;
   logic                  r_unf;

   assign w_clk    = WCLK ^ IS_WCLK_INVERTED;
   assign w_rd_acc = RD_EN & ~r_empty;
   // A pop on the same edge frees the slot, so a full FIFO can still write.
   assign w_wr_acc = WR_EN & (~r_full | w_rd_acc);

   always_comb begin
      w_cnt_n = r_cnt;
      unique case ({w_wr_acc, w_rd_acc})
         2'b10:   w_cnt_n = r_cnt + 1'b1;
         2'b01:   w_cnt_n = r_cnt - 1'b1;
         default: w_cnt_n = r_cnt;
      endcase
   end

   always_ff @(posedge w_clk or negedge RST_N) begin
      if (!RST_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_afull  <= (THR_C == '0);
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_cnt   <= w_cnt_n;
         r_empty <= (w_cnt_n == '0);
         r_full  <= (w_cnt_n == DEPTH_C);
         r_afull <= (w_cnt_n >= THR_C);
         if (WR_EN & r_full & ~w_rd_acc) r_ovf <= 1'b1;
         if (RD_EN & r_empty)            r_unf <= 1'b1;
      end
   end

   lutram_sdp #(
      .DATA_WIDTH       (DATA_WIDTH),
      .ADDR_WIDTH       (ADDR_WIDTH),
      .IS_WCLK_INVERTED (IS_WCLK_INVERTED)
   ) u_mem (
      .i_wclk (WCLK),
      .i_we   (w_wr_acc),
      .i_wa   (r_wr_ptr),
      .i_wd   (WR_DATA),
      .i_ra   (r_rd_ptr),
      .o_rd   (RD_DATA)
   );

   assign EMPTY       = r_empty;
   assign FULL        = r_full;
   assign ALMOST_FULL = r_afull;
   assign COUNT       = r_cnt;
   assign OVERFLOW    = r_ovf;
   assign UNDERFLOW   = r_unf;

endmodule

// File: tb/tb_lutram_fifo.sv
// Directed bench for lutram_fifo at 8x16 with threshold 14.
module tb_lutram_fifo;

   logic       WCLK;
   logic       RST_N;
   logic       WR_EN;
   logic [7:0] WR_DATA;
   logic       RD_EN;
   logic [7:0] RD_DATA;
   logic       EMPTY;
   logic       FULL;
   logic       ALMOST_FULL;
   logic [4:0] COUNT;
   logic       OVERFLOW;
   logic       UNDERFLOW;

   int total = 0;
   int bad   = 0;

   lutram_fifo #(
      .DATA_WIDTH       (8),
      .ADDR_WIDTH       (4),
      .AFULL_THRESH     (14),
      .IS_WCLK_INVERTED (1'b0)
   ) dut (
      .WCLK        (WCLK),
      .RST_N       (RST_N),
      .WR_EN       (WR_EN),
      .WR_DATA     (WR_DATA),
      .RD_EN       (RD_EN),
      .RD_DATA     (RD_DATA),
      .EMPTY       (EMPTY),
      .FULL        (FULL),
      .ALMOST_FULL (ALMOST_FULL),
      .COUNT       (COUNT),
      .OVERFLOW    (OVERFLOW),
      .UNDERFLOW   (UNDERFLOW)
   );

   initial WCLK = 1'b0;
   always #5 WCLK = ~WCLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic we, input logic [7:0] wd,
                      input logic re);
      WR_EN   = we;
      WR_DATA = wd;
      RD_EN   = re;
      @(posedge WCLK);
      #1;
      WR_EN = 1'b0;
      RD_EN = 1'b0;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      @(posedge WCLK);
      @(posedge WCLK);
      #1;
      RST_N = 1'b1;
      @(posedge WCLK);
      #1;
   endtask

   initial begin
      RST_N   = 1'b0;
      WR_EN   = 1'b0;
      RD_EN   = 1'b0;
      WR_DATA = '0;
      @(posedge WCLK);
      #1;
      chk("rst_empty", EMPTY, 1);
      chk("rst_full", FULL, 0);
      chk("rst_afull", ALMOST_FULL, 0);
      chk("rst_count", COUNT, 0);
      chk("rst_ovf", OVERFLOW, 0);
      chk("rst_unf", UNDERFLOW, 0);
      RST_N = 1'b1;
      @(posedge WCLK);
      #1;

      cyc(1'b1, 8'hA5, 1'b0);
      chk("w1_empty", EMPTY, 0);
      chk("w1_count", COUNT, 1);
      chk("w1_data", RD_DATA, 8'hA5);
      cyc(1'b0, 8'h00, 1'b1);
      chk("p1_empty", EMPTY, 1);
      chk("p1_count", COUNT, 0);
      chk("p1_unf", UNDERFLOW, 0);

      do_reset();
      for (int i = 0; i < 13; i++) cyc(1'b1, 8'(i), 1'b0);
      chk("c13_count", COUNT, 13);
      chk("c13_afull", ALMOST_FULL, 0);
      cyc(1'b1, 8'h0D, 1'b0);
      chk("c14_afull", ALMOST_FULL, 1);
      chk("c14_full", FULL, 0);
      cyc(1'b1, 8'h0E, 1'b0);
      chk("c15_full", FULL, 0);
      cyc(1'b1, 8'h0F, 1'b0);
      chk("c16_full", FULL, 1);
      chk("c16_count", COUNT, 16);
      chk("c16_head", RD_DATA, 8'h00);

      cyc(1'b1, 8'h77, 1'b1);
      chk("fwr_count", COUNT, 16);
      chk("fwr_full", FULL, 1);
      chk("fwr_ovf", OVERFLOW, 0);
      chk("fwr_head", RD_DATA, 8'h01);

      cyc(1'b1, 8'hFF, 1'b0);
      chk("ovf_flag", OVERFLOW, 1);
      chk("ovf_count", COUNT, 16);
      chk("ovf_head", RD_DATA, 8'h01);

      for (int i = 1; i < 16; i++) begin
         chk($sformatf("drain_%0d", i), RD_DATA, 32'(i));
         cyc(1'b0, 8'h00, 1'b1);
      end
      chk("drain_last", RD_DATA, 8'h77);
      chk("drain_lcnt", COUNT, 1);
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_empty", EMPTY, 1);
      chk("drain_ovf", OVERFLOW, 1);
      chk("drain_unf", UNDERFLOW, 0);

      cyc(1'b1, 8'h3C, 1'b1);
      chk("ewr_unf", UNDERFLOW, 1);
      chk("ewr_count", COUNT, 1);
      chk("ewr_data", RD_DATA, 8'h3C);
      chk("ewr_empty", EMPTY, 0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("ewr_pop", COUNT, 0);

      do_reset();
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         chk($sformatf("pw_cnt_%0d", i), COUNT, 1);
         chk($sformatf("pw_dat_%0d", i), RD_DATA, 32'(i));
         cyc(1'b0, 8'h00, 1'b1);
         chk($sformatf("pr_cnt_%0d", i), COUNT, 0);
      end
      chk("pair_empty", EMPTY, 1);
      chk("pair_unf", UNDERFLOW, 0);

      cyc(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
      cyc(1'b1, 8'h00, 1'b0);
      chk("pre_count", COUNT, 10);
      cyc(1'b0, 8'h00, 1'b1);
      chk("pre_count9", COUNT, 9);
      chk("pre_unf", UNDERFLOW, 1);
      @(negedge WCLK);
      RST_N = 1'b0;
      #1;
      chk("arst_count", COUNT, 0);
      chk("arst_empty", EMPTY, 1);
      chk("arst_full", FULL, 0);
      chk("arst_afull", ALMOST_FULL, 0);
      chk("arst_unf", UNDERFLOW, 0);
      chk("arst_ovf", OVERFLOW, 0);
      #2;
      RST_N = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      chk("rel_empty", EMPTY, 1);
      chk("rel_unf", UNDERFLOW, 0);
      chk("rel_ovf", OVERFLOW, 0);
      chk("rel_count", COUNT, 0);
      cyc(1'b1, 8'h5A, 1'b0);
      chk("rel_wdata", RD_DATA, 8'h5A);
      chk("rel_wcnt", COUNT, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
